sample_double_buffer: RTL and testbench

Ping-pong sample store between the audio front end and `fft_controller`. It accepts a stream of real time-domain samples into one bank while the FFT reads the other bank. When a bank fills, it swaps banks and issues a one-cycle `o_data_ready` pulse. It serves random-address reads with 1-cycle registered latency and refuses to overwrite a bank the FFT has not released.

---
 rtl/sample_double_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_sample_double_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_double_buffer.sv
// -----------------------------------------------------------------------------
// sample_double_buffer
//
// Ping-pong sample store between the audio front end and the FFT controller.
// Incoming samples fill the write bank while the FFT reads the other bank.
// When the write bank is full and the read bank has been released by the FFT,
// the banks swap and o_data_ready pulses for one cycle. If the read bank is
// still locked, the writer parks in FULL and discards further samples.
//
// Ports:
//   clk             clock, all logic on rising edge
//   reset           synchronous, active-high reset
//   i_sample_valid  i_sample is valid this cycle
//   i_sample        incoming sample (stored verbatim)
//   i_read_addr     read address into the read bank
//   o_read_data     registered read data (1-cycle latency)
//   i_fft_busy      FFT engine busy flag
//   o_data_ready    one-cycle pulse: a full bank is now the read bank
//   o_drop          combinational pulse: the presented sample is discarded
//   o_overflow      sticky drop flag, cleared only by reset
// -----------------------------------------------------------------------------
module sample_double_buffer #(
    parameter int FFT_POINTS = 512,
    parameter int DATA_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_sample_valid,
    input  logic [DATA_WIDTH-1:0]         i_sample,
    input  logic [$clog2(FFT_POINTS)-1:0] i_read_addr,
    output logic [DATA_WIDTH-1:0]         o_read_data,
    input  logic                          i_fft_busy,
    output logic                          o_data_ready,
    output logic                          o_drop,
    output logic                          o_overflow
);

    localparam int AW    = $clog2(FFT_POINTS);
    localparam int DEPTH = 2 * FFT_POINTS;
    localparam logic [AW-1:0] LAST_IDX = AW'(FFT_POINTS - 1);

    typedef enum logic [0:0] {
        WR_FILL = 1'b0,
        WR_FULL = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        LK_UNLOCKED  = 2'b00,
        LK_WAIT_BUSY = 2'b01,
        LK_BUSY      = 2'b10
    } lock_state_t;

    wr_state_t   wr_state_r;
    wr_state_t   wr_state_next_s;
    lock_state_t lock_r;
    lock_state_t lock_next_s;

    logic          wr_bank_r;
    logic          rd_bank_s;
    logic [AW-1:0] wptr_r;

    logic we_s;
    logic wptr_inc_s;
    logic swap_s;
    logic drop_s;

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] read_data_r;
    logic                  data_ready_r;
    logic                  overflow_r;

    // The reader always sees the bank the writer is not using.
    assign rd_bank_s = ~wr_bank_r;

    // Writer FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_r <= WR_FILL;
        end else begin
            wr_state_r <= wr_state_next_s;
        end
    end

    // Writer FSM next state. The lock is judged from its registered value, so
    // an unlock on the same edge as the last sample still sends us to FULL.
    always_comb begin
        wr_state_next_s = wr_state_r;
        case (wr_state_r)
            WR_FILL: begin
                if (i_sample_valid && (wptr_r == LAST_IDX) && (lock_r != LK_UNLOCKED)) begin
                    wr_state_next_s = WR_FULL;
                end else begin
                    wr_state_next_s = WR_FILL;
                end
            end
            WR_FULL: begin
                if (lock_r == LK_UNLOCKED) begin
                    wr_state_next_s = WR_FILL;
                end else begin
                    wr_state_next_s = WR_FULL;
                end
            end
            default: wr_state_next_s = WR_FILL;
        endcase
    end

    // Writer FSM outputs: write strobe, pointer advance, bank swap and drop.
    always_comb begin
        we_s       = 1'b0;
        wptr_inc_s = 1'b0;
        swap_s     = 1'b0;
        drop_s     = 1'b0;
        if (reset) begin
            we_s       = 1'b0;
            wptr_inc_s = 1'b0;
            swap_s     = 1'b0;
            drop_s     = 1'b0;
        end else begin
            case (wr_state_r)
                WR_FILL: begin
                    we_s = i_sample_valid;
                    if (i_sample_valid && (wptr_r != LAST_IDX)) begin
                        wptr_inc_s = 1'b1;
                    end else if (i_sample_valid && (lock_r == LK_UNLOCKED)) begin
                        swap_s = 1'b1;
                    end else begin
                        wptr_inc_s = 1'b0;
                    end
                end
                WR_FULL: begin
                    // A sample arriving in the swap cycle is still discarded.
                    drop_s = i_sample_valid;
                    swap_s = (lock_r == LK_UNLOCKED);
                end
                default: begin
                    we_s = 1'b0;
                end
            endcase
        end
    end

    // Lock FSM next state: a swap always re-arms the lock.
    always_comb begin
        lock_next_s = lock_r;
        if (swap_s) begin
            lock_next_s = LK_WAIT_BUSY;
        end else begin
            case (lock_r)
                LK_UNLOCKED:  lock_next_s = LK_UNLOCKED;
                LK_WAIT_BUSY: lock_next_s = i_fft_busy ? LK_BUSY : LK_WAIT_BUSY;
                LK_BUSY:      lock_next_s = i_fft_busy ? LK_BUSY : LK_UNLOCKED;
                default:      lock_next_s = LK_UNLOCKED;
            endcase
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_r <= LK_UNLOCKED;
        end else begin
            lock_r <= lock_next_s;
        end
    end

    // Write bank and write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_r <= 1'b0;
            wptr_r    <= '0;
        end else if (swap_s) begin
            wr_bank_r <= ~wr_bank_r;
            wptr_r    <= '0;
        end else if (wptr_inc_s) begin
            wptr_r <= wptr_r + AW'(1);
        end else begin
            wptr_r <= wptr_r;
        end
    end

    // Sample storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[{wr_bank_r, wptr_r}] <= i_sample;
        end
    end

    // Registered read port, unconditional every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_r <= '0;
        end else begin
            read_data_r <= mem_r[{rd_bank_s, i_read_addr}];
        end
    end

    // Ready pulse follows the swap edge; overflow latches any drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_ready_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            data_ready_r <= swap_s;
            overflow_r   <= overflow_r | drop_s;
        end
    end

    assign o_read_data  = read_data_r;
    assign o_data_ready = data_ready_r;
    assign o_drop       = drop_s;
    assign o_overflow   = overflow_r;

endmodule

// File: tb/tb_sample_double_buffer.sv
// -----------------------------------------------------------------------------
// tb_sample_double_buffer
//
// Directed self-checking bench for sample_double_buffer. One task per
// scenario, each with its own inline comparisons; ready and drop pulses are
// tallied on the falling edge so the tasks can compare pulse counts.
// -----------------------------------------------------------------------------
module tb_sample_double_buffer;

    localparam int N  = 512;
    localparam int DW = 24;
    localparam int AW = 9;

    logic          clk;
    logic          reset;
    logic          i_sample_valid;
    logic [DW-1:0] i_sample;
    logic [AW-1:0] i_read_addr;
    logic [DW-1:0] o_read_data;
    logic          i_fft_busy;
    logic          o_data_ready;
    logic          o_drop;
    logic          o_overflow;

    int total;
    int bad;
    int ready_total;
    int drop_total;

    sample_double_buffer #(
        .FFT_POINTS (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_read_addr    (i_read_addr),
        .o_read_data    (o_read_data),
        .i_fft_busy     (i_fft_busy),
        .o_data_ready   (o_data_ready),
        .o_drop         (o_drop),
        .o_overflow     (o_overflow)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tallies, sampled mid-cycle when everything is settled.
    initial begin
        ready_total = 0;
        drop_total  = 0;
    end
    always @(negedge clk) begin
        if (o_data_ready === 1'b1) ready_total = ready_total + 1;
        if (o_drop === 1'b1)       drop_total  = drop_total + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        i_sample_valid = 1'b0;
        i_fft_busy     = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Read every address of the read bank and compare with base + address.
    task automatic check_frame(input string name, input logic [DW-1:0] base);
        for (int a = 0; a < N; a++) begin
            i_read_addr = AW'(a);
            step();
            total++;
            if (o_read_data !== base + DW'(a)) begin
                bad++;
                $display("FAIL %s addr %0d: got %h expected %h", name, a, o_read_data, base + DW'(a));
            end
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        i_sample_valid = 1'b1;
        i_sample       = 24'h123456;
        i_fft_busy     = 1'b0;
        i_read_addr    = '0;
        step();
        step();
        total += 4;
        if (o_read_data !== 24'h000000) begin bad++; $display("FAIL reset_read_data: got %h expected 000000", o_read_data); end
        if (o_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", o_data_ready); end
        if (o_drop !== 1'b0) begin bad++; $display("FAIL reset_drop: got %b expected 0", o_drop); end
        if (o_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
        i_sample_valid = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic test_basic_fill();
        int r0, d0;
        do_reset();
        r0 = ready_total;
        d0 = drop_total;
        for (int i = 0; i < N; i++) begin
            i_sample_valid = 1'b1;
            i_sample       = DW'(i);
            step();
        end
        i_sample_valid = 1'b0;
        total += 2;
        if (o_data_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_after_last: got %b expected 1", o_data_ready); end
        if (ready_total - r0 !== 0) begin bad++; $display("FAIL basic_early_ready: got %0d pulses expected 0", ready_total - r0); end
        step();
        total += 3;
        if (o_data_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_width: got %b expected 0", o_data_ready); end
        if (ready_total - r0 !== 1) begin bad++; $display("FAIL basic_ready_count: got %0d expected 1", ready_total - r0); end
        if (drop_total - d0 !== 0) begin bad++; $display("FAIL basic_drops: got %0d expected 0", drop_total - d0); end
        check_frame("basic_read", 24'h000000);
    endtask

    task automatic test_back_to_back();
        int r0, d0;
        int bstart;
        do_reset();
        r0     = ready_total;
        d0     = drop_total;
        bstart = 1 << 30;
        for (int c = 0; c < 2560; c++) begin
            i_sample_valid = (c % 2 == 0);
            if (c < 2048) i_sample = DW'(c / 2);
            else          i_sample = DW'(1024 + (c - 2048) / 2);
            i_fft_busy = (c >= bstart) && (c < bstart + 600);
            if (c >= 2048) i_read_addr = AW'(c - 2048);
            step();
            if (o_data_ready === 1'b1) bstart = c + 3;
            if (c == 2047) begin
                total += 2;
                if (ready_total - r0 !== 2) begin bad++; $display("FAIL b2b_ready_count: got %0d expected 2", ready_total - r0); end
                if (drop_total - d0 !== 0) begin bad++; $display("FAIL b2b_drops: got %0d expected 0", drop_total - d0); end
            end
            if (c >= 2048) begin
                total++;
                if (o_read_data !== DW'(512 + c - 2048)) begin
                    bad++;
                    $display("FAIL b2b_read addr %0d: got %h expected %h", c - 2048, o_read_data, DW'(512 + c - 2048));
                end
            end
        end
        i_sample_valid = 1'b0;
        total++;
        if (drop_total - d0 !== 0) begin bad++; $display("FAIL b2b_drops_during_read: got %0d expected 0", drop_total - d0); end
    endtask

    task automatic test_overflow();
        int r0, d0;
        logic busy_latch;
        do_reset();
        r0         = ready_total;
        d0         = drop_total;
        busy_latch = 1'b0;
        for (int i = 0; i < 1034; i++) begin
            i_sample_valid = 1'b1;
            i_sample       = DW'(i);
            i_fft_busy     = busy_latch;
            #1;
            if (i == 1023) begin
                total++;
                if (o_drop !== 1'b0) begin bad++; $display("FAIL ovf_last_accepted_drop: got %b expected 0", o_drop); end
            end
            if (i == 1024) begin
                total += 2;
                if (o_drop !== 1'b1) begin bad++; $display("FAIL ovf_first_drop: got %b expected 1", o_drop); end
                if (o_overflow !== 1'b0) begin bad++; $display("FAIL ovf_overflow_early: got %b expected 0", o_overflow); end
            end
            step();
            if (o_data_ready === 1'b1) busy_latch = 1'b1;
        end
        i_sample_valid = 1'b0;
        total += 3;
        if (drop_total - d0 !== 10) begin bad++; $display("FAIL ovf_drop_count: got %0d expected 10", drop_total - d0); end
        if (ready_total - r0 !== 1) begin bad++; $display("FAIL ovf_ready_count: got %0d expected 1", ready_total - r0); end
        if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", o_overflow); end
        // Busy falls: this edge unlocks, the next one swaps.
        i_fft_busy = 1'b0;
        step();
        total++;
        if (o_data_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready_on_unlock_edge: got %b expected 0", o_data_ready); end
        i_sample_valid = 1'b1;
        i_sample       = 24'hBBBBBB;
        #1;
        total++;
        if (o_drop !== 1'b1) begin bad++; $display("FAIL ovf_swap_cycle_drop: got %b expected 1", o_drop); end
        step();
        i_sample_valid = 1'b0;
        total += 2;
        if (o_data_ready !== 1'b1) begin bad++; $display("FAIL ovf_ready_after_swap: got %b expected 1", o_data_ready); end
        if (drop_total - d0 !== 11) begin bad++; $display("FAIL ovf_total_drops: got %0d expected 11", drop_total - d0); end
        check_frame("ovf_frame2", 24'h000200);
        total++;
        if (o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_still_sticky: got %b expected 1", o_overflow); end
    endtask

    task automatic test_reset_mid_fill();
        int r0;
        // Overflow is still set from the previous scenario; reset must clear it.
        for (int i = 0; i < 300; i++) begin
            i_sample_valid = 1'b1;
            i_sample       = 24'h0F0000 + DW'(i);
            step();
        end
        reset          = 1'b1;
        i_sample       = 24'hEEEEEE;
        step();
        total += 4;
        if (o_read_data !== 24'h000000) begin bad++; $display("FAIL midrst_read_data: got %h expected 000000", o_read_data); end
        if (o_data_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b expected 0", o_data_ready); end
        if (o_drop !== 1'b0) begin bad++; $display("FAIL midrst_drop: got %b expected 0", o_drop); end
        if (o_overflow !== 1'b0) begin bad++; $display("FAIL midrst_overflow: got %b expected 0", o_overflow); end
        reset = 1'b0;
        r0    = ready_total;
        for (int i = 0; i < N; i++) begin
            i_sample_valid = 1'b1;
            i_sample       = 24'h300000 + DW'(i);
            step();
        end
        i_sample_valid = 1'b0;
        total += 2;
        if (ready_total - r0 !== 0) begin bad++; $display("FAIL midrst_early_ready: got %0d pulses expected 0", ready_total - r0); end
        if (o_data_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_after_512: got %b expected 1", o_data_ready); end
        check_frame("midrst_read", 24'h300000);
    endtask

    task automatic test_lock_handshake();
        int r0;
        do_reset();
        r0 = ready_total;
        for (int i = 0; i < 2 * N; i++) begin
            i_sample_valid = 1'b1;
            i_sample       = (i < N) ? 24'h100000 + DW'(i) : 24'h200000 + DW'(i - N);
            step();
        end
        i_sample_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        total++;
        if (ready_total - r0 !== 1) begin bad++; $display("FAIL lock_no_swap_wait_busy: got %0d pulses expected 1", ready_total - r0); end
        i_fft_busy = 1'b1;
        for (int i = 0; i < 5; i++) step();
        total++;
        if (ready_total - r0 !== 1) begin bad++; $display("FAIL lock_no_swap_busy: got %0d pulses expected 1", ready_total - r0); end
        i_fft_busy = 1'b0;
        step();
        total++;
        if (o_data_ready !== 1'b0) begin bad++; $display("FAIL lock_ready_on_unlock_edge: got %b expected 0", o_data_ready); end
        step();
        total += 2;
        if (o_data_ready !== 1'b1) begin bad++; $display("FAIL lock_ready_after_unlock: got %b expected 1", o_data_ready); end
        if (o_drop !== 1'b0) begin bad++; $display("FAIL lock_drop: got %b expected 0", o_drop); end
    endtask

    task automatic test_read_isolation();
        int r0, d0;
        step();
        r0 = ready_total;
        d0 = drop_total;
        for (int a = 0; a < N; a++) begin
            i_sample_valid = 1'b1;
            i_sample       = 24'hAAAAAA;
            i_read_addr    = AW'(a);
            step();
            total++;
            if (o_read_data !== 24'h200000 + DW'(a)) begin
                bad++;
                $display("FAIL iso_read addr %0d: got %h expected %h", a, o_read_data, 24'h200000 + DW'(a));
            end
        end
        i_sample_valid = 1'b0;
        step();
        total += 2;
        if (ready_total - r0 !== 0) begin bad++; $display("FAIL iso_ready: got %0d pulses expected 0", ready_total - r0); end
        if (drop_total - d0 !== 0) begin bad++; $display("FAIL iso_drops: got %0d expected 0", drop_total - d0); end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_read_addr    = '0;
        i_fft_busy     = 1'b0;
        test_reset();
        test_basic_fill();
        test_back_to_back();
        test_overflow();
        test_reset_mid_fill();
        test_lock_handshake();
        test_read_isolation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
